// File: rtl/lcd_report_arbiter.sv
// lcd_report_arbiter
//   Lets N switch ports take turns reporting a forwarded frame on the single
//   text_lcd display. Pending requests are served in round-robin order. The
//   winner's {DST,SRC} address byte and payload byte are latched onto the LCD
//   lines and held for HOLD_CYCLES cycles, so the LCD refresh loop has time to
//   show the report before the next one replaces it.
//
// Ports
//   clk          system clock (50 MHz)
//   rst          synchronous reset, active low
//   req          per-port report request (level, held until ack)
//   addr_bus     port i address byte at [8i+7:8i], {DST[3:0],SRC[3:0]}
//   payload_bus  port i payload byte at [8i+7:8i]
//   ack          one-hot, single-cycle grant acknowledge
//   addr_out     to text_lcd addr_in
//   payload_out  to text_lcd payload_in
//   grant_id     index of the last granted port
//   busy         high while a report is in its dwell window
//   disp_count   number of reports granted, wraps at 256
//
// Build option
//   LCD_DISP_CNT_EN  when defined, disp_count counts grants. When it is not
//                    defined there is no counter and disp_count is 8'h00.
module lcd_report_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int HOLD_CYCLES = 2500,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   req,
  input  logic [8*N_PORTS-1:0] addr_bus,
  input  logic [8*N_PORTS-1:0] payload_bus,
  output logic [N_PORTS-1:0]   ack,
  output logic [7:0]           addr_out,
  output logic [7:0]           payload_out,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [7:0]           disp_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [N_PORTS-1:0] r_ack, w_ack_nxt;
  logic [7:0]         r_addr, w_addr_nxt;
  logic [7:0]         r_pay, w_pay_nxt;
  logic [2:0]         r_gid, w_gid_nxt;
  logic               r_busy, w_busy_nxt;
  logic [2:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

  logic               w_any;
  logic [2:0]         w_sel;
  logic               w_grant;

  // Rotating-priority search. The offsets are scanned from the highest to
  // the lowest, so the requester nearest to rr_ptr is written last and wins.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = |req;
    w_sel = r_rr_ptr;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      if (req[idx]) w_sel = 3'(idx);
    end
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_ack_nxt    = '0;
    w_addr_nxt   = r_addr;
    w_pay_nxt    = r_pay;
    w_gid_nxt    = r_gid;
    w_busy_nxt   = r_busy;
    w_rr_ptr_nxt = r_rr_ptr;
    w_cnt_nxt    = r_cnt;
    w_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant          = 1'b1;
          w_ack_nxt[w_sel] = 1'b1;
          w_addr_nxt       = addr_bus[int'(w_sel)*8 +: 8];
          w_pay_nxt        = payload_bus[int'(w_sel)*8 +: 8];
          w_gid_nxt        = w_sel;
          w_busy_nxt       = 1'b1;
          w_cnt_nxt        = CNT_W'(HOLD_CYCLES - 1);
          w_rr_ptr_nxt     = (w_sel == 3'(N_PORTS - 1)) ? 3'd0 : w_sel + 3'd1;
          w_state_nxt      = HOLD;
        end
      end
      HOLD: begin
        // req is not looked at here. The requester drops it in the cycle
        // after ack, and because the dwell is at least 2 cycles that stale
        // level is never sampled.
        if (r_cnt == '0) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_ack    <= '0;
      r_addr   <= '0;
      r_pay    <= '0;
      r_gid    <= '0;
      r_busy   <= 1'b0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      r_addr   <= w_addr_nxt;
      r_pay    <= w_pay_nxt;
      r_gid    <= w_gid_nxt;
      r_busy   <= w_busy_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

`ifdef LCD_DISP_CNT_EN
  logic [7:0] r_disp;
  always_ff @(posedge clk) begin
    if (!rst)         r_disp <= '0;
    else if (w_grant) r_disp <= r_disp + 8'd1;
  end
  assign disp_count = r_disp;
`else
  logic w_unused_grant;
  assign w_unused_grant = w_grant;
  assign disp_count     = 8'h00;
`endif

  assign ack         = r_ack;
  assign addr_out    = r_addr;
  assign payload_out = r_pay;
  assign grant_id    = r_gid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_lcd_report_arbiter.sv
module tb_lcd_report_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] addr_bus = '0, payload_bus = '0;
  logic [3:0]  ack;
  logic [7:0]  addr_out, payload_out, disp_count;
  logic [2:0]  grant_id;
  logic        busy;

  int checks = 0, errors = 0, exp_disp = 0;

  logic [7:0] a_v [4] = '{8'h1F, 8'h2E, 8'h3D, 8'h4C};
  logic [7:0] p_v [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  lcd_report_arbiter #(.N_PORTS(4), .HOLD_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_bus(addr_bus),
    .payload_bus(payload_bus), .ack(ack), .addr_out(addr_out),
    .payload_out(payload_out), .grant_id(grant_id), .busy(busy),
    .disp_count(disp_count));

  always #10 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] ab, pb;
    logic [3:0]  e_ack;
    logic [7:0]  e_addr, e_pay;
    logic [2:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] disp_exp();
`ifdef LCD_DISP_CNT_EN
    return 8'(exp_disp);
`else
    return 8'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    exp_disp = 0;
    rst = 1'b1;
  endtask

  // Waits for the next ack, checking it came from port p exactly gap cycles
  // after the previous ack (or after req was raised).
  task automatic wait_grant(input int p, input int gap, input bit drop);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      step();
      n++;
      if (ack != '0) begin
        got = 1'b1;
        exp_disp = (exp_disp + 1) % 256;
        chk("grant_ack", 32'(ack), 32'(1 << p));
        chk("grant_gap", n, gap);
        chk("grant_addr", 32'(addr_out), 32'(a_v[p]));
        chk("grant_pay", 32'(payload_out), 32'(p_v[p]));
        chk("grant_id", 32'(grant_id), p);
        chk("grant_busy", 32'(busy), 1);
        chk("grant_disp", 32'(disp_count), 32'(disp_exp()));
        if (drop) req[p] = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: no ack for port %0d within 40 cycles", p);
    end
  endtask

  initial begin
    // reset rows with arbitrary requests present
    tv[0] = '{1'b0, 4'b1011, 32'hDEADBEEF, 32'h12345678, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0};
    tv[1] = '{1'b0, 4'b0110, 32'hDEADBEEF, 32'h12345678, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0};
    tv[2] = '{1'b0, 4'b1111, 32'hDEADBEEF, 32'h12345678, 4'h0, 8'h00, 8'h00, 3'd0, 1'b0};
    // port 2 reports CA/05, then drops req; 8 cycles of dwell, then idle hold
    tv[3] = '{1'b1, 4'b0100, 32'h00CA0000, 32'h00050000, 4'b0100, 8'hCA, 8'h05, 3'd2, 1'b1};
    for (int i = 4; i <= 10; i++)
      tv[i] = '{1'b1, 4'b0000, 32'h0, 32'h0, 4'h0, 8'hCA, 8'h05, 3'd2, 1'b1};
    for (int i = 11; i <= 12; i++)
      tv[i] = '{1'b1, 4'b0000, 32'h0, 32'h0, 4'h0, 8'hCA, 8'h05, 3'd2, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst = tv[i].rst; req = tv[i].rq;
      addr_bus = tv[i].ab; payload_bus = tv[i].pb;
      step();
      if (!tv[i].rst) exp_disp = 0;
      else if (tv[i].e_ack != '0) exp_disp++;
      chk($sformatf("tv%0d_ack", i), 32'(ack), 32'(tv[i].e_ack));
      chk($sformatf("tv%0d_addr", i), 32'(addr_out), 32'(tv[i].e_addr));
      chk($sformatf("tv%0d_pay", i), 32'(payload_out), 32'(tv[i].e_pay));
      chk($sformatf("tv%0d_gid", i), 32'(grant_id), 32'(tv[i].e_gid));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("tv%0d_disp", i), 32'(disp_count), 32'(disp_exp()));
    end

    addr_bus    = {a_v[3], a_v[2], a_v[1], a_v[0]};
    payload_bus = {p_v[3], p_v[2], p_v[1], p_v[0]};

    // all four together: order 0,1,2,3 spaced HOLD+1
    do_reset();
    req = 4'b1111;
    wait_grant(0, 1, 1'b1);
    wait_grant(1, 9, 1'b1);
    wait_grant(2, 9, 1'b1);
    wait_grant(3, 9, 1'b1);

    // after port 2 wins, 0 and 3 collide: 3 first, then wrap to 0
    do_reset();
    req = 4'b0100;
    wait_grant(2, 1, 1'b1);
    req = 4'b1001;
    wait_grant(3, 9, 1'b1);
    wait_grant(0, 9, 1'b1);

    // reset during dwell while port 1 keeps requesting
    do_reset();
    req = 4'b0010;
    wait_grant(1, 1, 1'b0);
    step(); step(); step();
    rst = 1'b0;
    step();
    exp_disp = 0;
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_addr", 32'(addr_out), 0);
    chk("midrst_pay", 32'(payload_out), 0);
    chk("midrst_gid", 32'(grant_id), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_disp", 32'(disp_count), 0);
    rst = 1'b1;
    wait_grant(1, 1, 1'b1);

    // grant counter: 3 grants, then 256 in total wraps to 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      req[0] = 1'b1;
      wait_grant(0, (i == 0) ? 1 : 9, 1'b1);
      if (i == 2) chk("disp_after3", 32'(disp_count), 32'(disp_exp()));
    end
    chk("disp_wrap", 32'(disp_count), 32'(disp_exp()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
